ps2_key_event_ctrl: RTL and testbench
=====================================

// Module: ps2_key_event_ctrl
// PURPOSE
//  Sequences raw PS/2 scan-code bytes from the keyboard receiver into decoded key events.
//  Tracks the E0 (extended) and F0 (break) prefixes and suppresses typematic repeats.
//  Buffers events in a FIFO with a valid/ready pop interface for the display/ASCII stage.
//  Also maintains the held-key status and a press counter for the seven-segment display.
// PARAMETERS
//  FIFO_DEPTH   8       event FIFO entries; power of 2, >=2; AW=$clog2(FIFO_DEPTH)
//  TIMEOUT_CYC  100000  max clk cycles allowed in a prefix state before abort
// PORTS
//  clk         in   1     system clock, all logic on posedge
//  resetn      in   1     asynchronous, active-low reset
//  rx_valid    in   1     1-cycle strobe: rx_byte holds a parity-checked byte
//  rx_byte     in   8     scan-code byte from the receiver
//  evt_ready   in   1     consumer accepts the head event this cycle
//  clr_ovf     in   1     synchronous clear of ovf
//  evt_valid   out  1     FIFO not empty; head event on evt_*
//  evt_code    out  8     head event scan code (prefixes stripped)
//  evt_ext     out  1     head event carried an E0 prefix
//  evt_brk     out  1     head event is a release (F0)
//  fifo_level  out  AW+1  number of entries in the FIFO, 0..FIFO_DEPTH
//  key_held    out  1     a make is held without a matching break
//  held_code   out  8     code of the held key (valid while key_held=1)
//  press_cnt   out  8     count of accepted, non-repeat makes; wraps 255->0
//  ovf         out  1     sticky: an event was dropped because the FIFO was full
//  proto_err   out  1     1-cycle pulse on a protocol error or timeout
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, timeout counter 0.
//  Only cycles with rx_valid=1 advance the FSM. The FSM has four states.
//  IDLE
//   E0 -> EXT.  F0 -> BRK.  00/FF -> ignored, stay IDLE.
//   Any other byte is a make with ext=0.
//  EXT
//   E0 -> stay in EXT.  F0 -> EXTBRK.  Other byte -> make with ext=1, then IDLE.
//  BRK / EXTBRK
//   E0 or F0 -> proto_err pulse, no event, IDLE.
//   Other byte -> break event (ext=0 in BRK, ext=1 in EXTBRK), then IDLE.
//  Make handling:
//   - If key_held and {held_ext,held_code} == {ext,byte}: typematic repeat; no event, no count.
//   - Otherwise: push {ext,0,byte}; set key_held=1 and {held_ext,held_code}={ext,byte};
//     press_cnt += 1.
//  Break handling:
//   - Always push {ext,1,byte}.
//   - key_held clears only if {ext,byte} matches the held key.
//  Timeout:
//   - The counter runs only in EXT, BRK or EXTBRK and is cleared by each rx_valid.
//   - On reaching TIMEOUT_CYC-1: proto_err pulse, FSM -> IDLE, counter cleared.
//   - rx_valid in that same cycle is processed from the current state instead; no timeout fires.
//  Latency: rx_valid at edge N -> event visible on evt_* / fifo_level after edge N+1.
//  FIFO:
//   - First-word-fall-through; evt_* are registered from the head entry.
//   - Pop occurs when evt_valid & evt_ready; evt_ready while empty is ignored.
//   - Push while full with no pop: event dropped and ovf<=1. FSM and held state still update.
//   - Push and pop in the same cycle, including when full: both happen, level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Sticky and derived outputs:
//   - ovf holds until clr_ovf; clr_ovf and a new overflow in the same cycle leave ovf=1.
//   - press_cnt is 8-bit modulo; held_code retains its last value after release.
//  resetn low mid-sequence: pending prefix, FIFO contents and counters are discarded immediately.
// TESTING
//  1. Bytes 1C,F0,1C -> events {0,0,1C},{0,1,1C}; press_cnt=1; key_held 1 then 0.
//  2. Bytes E0,75,E0,F0,75 -> events {1,0,75},{1,1,75}; key_held=0 at end.
//  3. Bytes 1C x5, then F0,1C -> exactly 2 events; press_cnt=1 (repeats suppressed).
//  4. evt_ready=0; 9 makes of distinct codes with FIFO_DEPTH=8 -> fifo_level=8, ovf=1,
//     9th event lost. Pop all -> codes in order. clr_ovf -> ovf=0.
//  5. E0 then idle TIMEOUT_CYC cycles -> one proto_err pulse; next 1C gives ext=0.
//     Also bytes F0,E0 -> proto_err, no event.
//  6. Full FIFO with evt_ready=1 and a new make in the same cycle -> level stays 8, no ovf.
//     Also: resetn low after E0 -> FIFO empty, press_cnt=0.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//
// Turns raw PS/2 scan-code bytes into decoded key events. It tracks the
// E0 (extended) and F0 (break) prefixes and drops typematic repeats of
// the key that is currently held. Decoded events are queued in a
// first-word-fall-through FIFO, which the display/ASCII stage drains
// through a valid/ready handshake.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   resetn     asynchronous, active-low reset
//   rx_valid   1-cycle strobe: rx_byte holds a parity-checked byte
//   rx_byte    scan-code byte from the receiver
//   evt_ready  consumer accepts the head event this cycle
//   clr_ovf    synchronous clear of ovf
//   evt_valid  FIFO not empty; the head event is on evt_*
//   evt_code   head event scan code, with prefixes stripped
//   evt_ext    head event carried an E0 prefix
//   evt_brk    head event is a release
//   fifo_level number of queued events, 0..FIFO_DEPTH
//   key_held   a make is held without a matching break
//   held_code  code of the last held key; kept after release
//   press_cnt  accepted non-repeat makes, modulo 256
//   ovf        sticky flag: an event was dropped because the FIFO was full
//   proto_err  1-cycle pulse on a bad prefix sequence or a prefix timeout

module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_byte,
    input  logic                          evt_ready,
    input  logic                          clr_ovf,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          key_held,
    output logic [7:0]                    held_code,
    output logic [7:0]                    press_cnt,
    output logic                          ovf,
    output logic                          proto_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
    logic            do_make, do_brk, cur_ext, err_n;
    logic            held_ext;
    logic            held_match;
    logic            push_req;

    // Decoded event waiting one cycle before it enters the FIFO
    logic            push_pend;
    logic [9:0]      push_data;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            fifo_full, pop, push_ok;
    logic [9:0]      head;

    // A make of the held key is a typematic repeat; a break of the held
    // key releases it. Both cases use the same comparison.
    assign held_match = key_held && (held_ext == cur_ext) && (held_code == rx_byte);
    assign push_req   = do_brk | (do_make & ~held_match);

    // State register, prefix timeout counter and the error pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= tmo_cnt_n;
            proto_err <= err_n;
        end
    end

    // Prefix decoding and timeout. A byte arriving in the cycle the
    // timeout would expire wins over the timeout.
    always_comb begin
        state_n   = state;
        tmo_cnt_n = tmo_cnt;
        do_make   = 1'b0;
        do_brk    = 1'b0;
        cur_ext   = 1'b0;
        err_n     = 1'b0;
        if (rx_valid) begin
            tmo_cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (rx_byte == 8'hE0) begin
                        state_n = ST_EXT;
                    end else if (rx_byte == 8'hF0) begin
                        state_n = ST_BRK;
                    end else if (rx_byte != 8'h00 && rx_byte != 8'hFF) begin
                        do_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    cur_ext = 1'b1;
                    if (rx_byte == 8'hF0) begin
                        state_n = ST_EXTBRK;
                    end else if (rx_byte != 8'hE0) begin
                        do_make = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    cur_ext = (state == ST_EXTBRK);
                    state_n = ST_IDLE;
                    if (rx_byte == 8'hE0 || rx_byte == 8'hF0) begin
                        err_n = 1'b1;
                    end else begin
                        do_brk = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                err_n     = 1'b1;
                state_n   = ST_IDLE;
                tmo_cnt_n = '0;
            end else begin
                tmo_cnt_n = tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt_n = '0;
        end
    end

    // Held-key status and press counter update right away, even when
    // the event itself is later dropped by a full FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_held  <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= '0;
            press_cnt <= '0;
            push_pend <= 1'b0;
            push_data <= '0;
        end else begin
            push_pend <= push_req;
            push_data <= {cur_ext, do_brk, rx_byte};
            if (do_make && !held_match) begin
                key_held  <= 1'b1;
                held_ext  <= cur_ext;
                held_code <= rx_byte;
                press_cnt <= press_cnt + 8'd1;
            end else if (do_brk && held_match) begin
                key_held  <= 1'b0;
            end
        end
    end

    assign fifo_full = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign evt_valid = (fifo_level != '0);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push_pend & (~fifo_full | pop);

    // Event storage; contents only matter where the pointers say so
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, level and the sticky overflow flag. A new overflow
    // takes priority over clr_ovf in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (push_pend && !push_ok) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Head entry drives the event outputs; blanked while empty so that
    // stale storage never shows up on the bus.
    assign head     = mem[rd_ptr];
    assign evt_code = evt_valid ? head[7:0] : 8'h00;
    assign evt_brk  = evt_valid & head[8];
    assign evt_ext  = evt_valid & head[9];

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
//
// Directed bench for ps2_key_event_ctrl, using a short prefix timeout.
// Inputs change 1 ns after each rising edge, and outputs are sampled
// at that same point.

module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic [3:0] fifo_level;
    logic       key_held;
    logic [7:0] held_code;
    logic [7:0] press_cnt;
    logic       ovf;
    logic       proto_err;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int err_base;

    ps2_key_event_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .evt_ready  (evt_ready),
        .clr_ovf    (clr_ovf),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_brk    (evt_brk),
        .fifo_level (fifo_level),
        .key_held   (key_held),
        .held_code  (held_code),
        .press_cnt  (press_cnt),
        .ovf        (ovf),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Counts cycles with proto_err high, so a stretched pulse counts twice
    always @(negedge clk) begin
        if (proto_err === 1'b1) begin
            err_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One received byte, held for exactly one clock
    task automatic applyStimulus(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic ext, input logic brk, input logic [7:0] code);
        checkOutput({tag, "_valid"}, evt_valid, 1'b1);
        checkOutput({tag, "_evt"}, {evt_ext, evt_brk, evt_code}, {ext, brk, code});
    endtask

    initial begin
        resetn    = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        step(3);
        resetn = 1'b1;
        step(1);

        // Reset state
        checkOutput("rst_valid", evt_valid, 1'b0);
        checkOutput("rst_level", fifo_level, 4'd0);
        checkOutput("rst_held", key_held, 1'b0);
        checkOutput("rst_press", press_cnt, 8'd0);
        checkOutput("rst_ovf", ovf, 1'b0);
        checkOutput("rst_perr", proto_err, 1'b0);
        checkOutput("rst_code", evt_code, 8'h00);

        // Plain make and break
        applyStimulus(8'h1C);
        step(1);
        checkOutput("t1_held_on", key_held, 1'b1);
        checkOutput("t1_level1", fifo_level, 4'd1);
        check_head("t1_make", 1'b0, 1'b0, 8'h1C);
        checkOutput("t1_press", press_cnt, 8'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        step(1);
        checkOutput("t1_held_off", key_held, 1'b0);
        checkOutput("t1_level2", fifo_level, 4'd2);
        pop_one();
        check_head("t1_brk", 1'b0, 1'b1, 8'h1C);
        pop_one();
        checkOutput("t1_empty", fifo_level, 4'd0);
        checkOutput("t1_heldcode", held_code, 8'h1C);

        // Extended make and extended break
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        step(1);
        checkOutput("t2_level", fifo_level, 4'd2);
        check_head("t2_make", 1'b1, 1'b0, 8'h75);
        checkOutput("t2_held", key_held, 1'b0);
        checkOutput("t2_press", press_cnt, 8'd2);
        pop_one();
        check_head("t2_brk", 1'b1, 1'b1, 8'h75);
        pop_one();

        // Typematic repeats are suppressed
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h1C);
        end
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        step(1);
        checkOutput("t3_level", fifo_level, 4'd2);
        checkOutput("t3_press", press_cnt, 8'd3);
        check_head("t3_make", 1'b0, 1'b0, 8'h1C);
        pop_one();
        check_head("t3_brk", 1'b0, 1'b1, 8'h1C);
        pop_one();

        // Overflow: the ninth make is dropped but still counted and held
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h11 + 8'(i));
        end
        step(1);
        checkOutput("t4_level", fifo_level, 4'd8);
        checkOutput("t4_ovf", ovf, 1'b1);
        checkOutput("t4_press", press_cnt, 8'd12);
        checkOutput("t4_heldcode", held_code, 8'h19);
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("t4_pop%0d", i), 1'b0, 1'b0, 8'h11 + 8'(i));
            pop_one();
        end
        checkOutput("t4_drained", fifo_level, 4'd0);
        checkOutput("t4_ovf_sticky", ovf, 1'b1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        checkOutput("t4_ovf_clr", ovf, 1'b0);

        // Full FIFO with simultaneous push and pop keeps the level
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h21 + 8'(i));
        end
        step(1);
        checkOutput("t6_full", fifo_level, 4'd8);
        rx_valid = 1'b1;
        rx_byte  = 8'h29;
        step(1);
        rx_valid  = 1'b0;
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        checkOutput("t6_level", fifo_level, 4'd8);
        checkOutput("t6_ovf", ovf, 1'b0);
        checkOutput("t6_press", press_cnt, 8'd21);
        check_head("t6_head", 1'b0, 1'b0, 8'h22);
        for (int i = 0; i < 7; i++) begin
            pop_one();
        end
        check_head("t6_last", 1'b0, 1'b0, 8'h29);
        pop_one();
        checkOutput("t6_empty", fifo_level, 4'd0);

        // Prefix timeout: no pulse before expiry, exactly one after
        err_base = err_seen;
        applyStimulus(8'hE0);
        step(TMO - 5);
        checkOutput("t5_no_early", err_seen - err_base, 0);
        step(10);
        checkOutput("t5_tmo_pulse", err_seen - err_base, 1);
        applyStimulus(8'h1C);
        step(1);
        check_head("t5_after_tmo", 1'b0, 1'b0, 8'h1C);
        checkOutput("t5_press", press_cnt, 8'd22);
        pop_one();

        // Prefix clash F0,E0 raises an error and produces no event
        err_base = err_seen;
        applyStimulus(8'hF0);
        applyStimulus(8'hE0);
        step(2);
        checkOutput("t5_clash_err", err_seen - err_base, 1);
        checkOutput("t5_clash_noevt", fifo_level, 4'd0);

        // Reset mid-sequence discards the queue, counters and prefix
        applyStimulus(8'h33);
        step(1);
        checkOutput("t7_pre_level", fifo_level, 4'd1);
        applyStimulus(8'hE0);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t7_rst_level", fifo_level, 4'd0);
        checkOutput("t7_rst_press", press_cnt, 8'd0);
        checkOutput("t7_rst_held", key_held, 1'b0);
        step(1);
        resetn = 1'b1;
        step(1);
        applyStimulus(8'h1C);
        step(1);
        check_head("t7_noprefix", 1'b0, 1'b0, 8'h1C);
        checkOutput("t7_press", press_cnt, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
